// File: rtl/isp_pkg.sv
// Shared types and defaults for the ISP kernel pipeline blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package isp_pkg;

    // Default coordinate / frame-dimension width (max frame 1023 x 1023)
    localparam int COORD_W_DFLT  = 10;
    // Default kernel edge length
    localparam int KRN_SIZE_DFLT = 3;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        EMIT   = 3'd4,
        FINISH = 3'd5
    } sched_state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster x/y window-position counter with per-frame wrap limits and a last-position flag.
// Latency: clear/advance take effect on the next rising edge; is_last is combinational from x/y.
// Backpressure: none; the caller pulses advance only when a window has been consumed.
module raster_counter
    import isp_pkg::*;
#(
    parameter int COORD_W = COORD_W_DFLT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    input  logic [COORD_W-1:0] last_x,
    input  logic [COORD_W-1:0] last_y,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               is_last
);

    // x steps along the row and wraps to 0 at last_x, bumping y; clear wins over advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == last_x) begin
                x <= '0;
                y <= y + COORD_W'(1);
            end else begin
                x <= x + COORD_W'(1);
            end
        end
    end

    // Final window of the frame: both coordinates at their limits
    always_comb begin
        is_last = (x == last_x) && (y == last_y);
    end

endmodule

// File: rtl/kernel_scheduler.sv
// Frame sequencer: walks every SIZE x SIZE window in raster order, fetch -> engine start -> done -> emit.
// Latency: frame_start->win_req 1 cycle, win_valid->krn_start 1, krn_done->out_valid 1, accept->win_req 1.
// Backpressure: out_valid/out_pixel/out_x/out_y hold until out_ready; no new fetch or start while stalled.
module kernel_scheduler
    import isp_pkg::*;
#(
    parameter int SIZE    = KRN_SIZE_DFLT,
    parameter int COORD_W = COORD_W_DFLT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] img_width,
    input  logic [COORD_W-1:0] img_height,
    output logic               win_req,
    output logic [COORD_W-1:0] win_x,
    output logic [COORD_W-1:0] win_y,
    input  logic               win_valid,
    output logic               krn_start,
    input  logic               krn_done,
    input  logic [7:0]         krn_pixel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_pixel,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               busy,
    output logic               frame_done
);

    sched_state_t       state;
    sched_state_t       state_nxt;
    logic               first_wait;
    logic [COORD_W-1:0] last_x;
    logic [COORD_W-1:0] last_y;
    logic [COORD_W-1:0] cnt_x;
    logic [COORD_W-1:0] cnt_y;
    logic               cnt_last;
    logic               frame_accept;
    logic               degenerate;
    logic               done_qual;
    logic               cnt_advance;
    logic [COORD_W:0]   span_x;
    logic [COORD_W:0]   span_y;

    // One extra bit so a dimension smaller than SIZE shows up as a negative span
    assign span_x       = {1'b0, img_width}  - (COORD_W+1)'(SIZE);
    assign span_y       = {1'b0, img_height} - (COORD_W+1)'(SIZE);
    assign degenerate   = span_x[COORD_W] | span_y[COORD_W];
    assign frame_accept = (state == IDLE) && frame_start;
    // The first WAIT cycle still sees the previous window's done level, so it never qualifies
    assign done_qual    = (state == WAIT) && krn_done && !first_wait;
    assign cnt_advance  = (state == EMIT) && out_ready && !cnt_last;
    assign busy         = (state != IDLE);
    assign win_x        = cnt_x;
    assign win_y        = cnt_y;

    raster_counter #(
        .COORD_W (COORD_W)
    ) u_raster_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (frame_accept),
        .advance (cnt_advance),
        .last_x  (last_x),
        .last_y  (last_y),
        .x       (cnt_x),
        .y       (cnt_y),
        .is_last (cnt_last)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and Moore handshake outputs
    always_comb begin
        state_nxt  = state;
        win_req    = 1'b0;
        krn_start  = 1'b0;
        out_valid  = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = degenerate ? FINISH : FETCH;
                end
            end
            FETCH: begin
                win_req = 1'b1;
                if (win_valid) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                krn_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (done_qual) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = cnt_last ? FINISH : FETCH;
                end
            end
            FINISH: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Marks the WAIT cycle that directly follows the engine start pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_wait <= 1'b0;
        end else begin
            first_wait <= (state == LAUNCH);
        end
    end

    // Window limits captured once per frame; later dimension changes do not disturb the walk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_x <= '0;
            last_y <= '0;
        end else if (frame_accept) begin
            last_x <= span_x[COORD_W-1:0];
            last_y <= span_y[COORD_W-1:0];
        end
    end

    // Result capture: engine pixel plus the coordinates of the window that produced it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pixel <= '0;
            out_x     <= '0;
            out_y     <= '0;
        end else if (done_qual) begin
            out_pixel <= krn_pixel;
            out_x     <= cnt_x;
            out_y     <= cnt_y;
        end
    end

endmodule

// File: tb/tb_kernel_scheduler.sv
// Directed bench for kernel_scheduler with a window-provider model and a fixed-latency engine model.
// Latency: provider answers one cycle after win_req; engine raises done nine cycles after krn_start.
// Backpressure: out_ready is driven per scenario; a negedge monitor checks hold and handshake rules.
module tb_kernel_scheduler;

    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic [CW-1:0] img_width;
    logic [CW-1:0] img_height;
    logic          win_req;
    logic [CW-1:0] win_x;
    logic [CW-1:0] win_y;
    logic          win_valid;
    logic          krn_start;
    logic          krn_done;
    logic [7:0]    krn_pixel;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_pixel;
    logic [CW-1:0] out_x;
    logic [CW-1:0] out_y;
    logic          busy;
    logic          frame_done;

    kernel_scheduler #(
        .SIZE    (3),
        .COORD_W (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .img_width   (img_width),
        .img_height  (img_height),
        .win_req     (win_req),
        .win_x       (win_x),
        .win_y       (win_y),
        .win_valid   (win_valid),
        .krn_start   (krn_start),
        .krn_done    (krn_done),
        .krn_pixel   (krn_pixel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pixel   (out_pixel),
        .out_x       (out_x),
        .out_y       (out_y),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Scenario knobs (written by the main sequence only)
    int exp_w     = 0;
    int exp_h     = 0;
    int done_hold = 1;   // 0 = done stays high until one cycle after the next start
    bit spur_en   = 1'b0;
    int fd_base   = 0;

    // Monitor counters (written by the monitor only)
    int fd_cnt     = 0;
    int ks_cnt     = 0;
    int out_total  = 0;
    int stall_cnt  = 0;
    int frame_outs = 0;

    logic [7:0] win_pix;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pixel the engine model returns for the window at (x, y)
    function automatic logic [7:0] pix_fn(input int x, input int y);
        logic [7:0] v;
        v = {x[3:0], y[3:0]};
        return v ^ 8'h3C;
    endfunction

    function automatic int exp_total();
        if (exp_w < 3 || exp_h < 3) return 0;
        return (exp_w - 2) * (exp_h - 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_win_req"},    32'(win_req),    32'd0);
        check({tag, "_krn_start"},  32'(krn_start),  32'd0);
        check({tag, "_out_valid"},  32'(out_valid),  32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_win_x"},      32'(win_x),      32'd0);
        check({tag, "_win_y"},      32'(win_y),      32'd0);
        check({tag, "_out_x"},      32'(out_x),      32'd0);
        check({tag, "_out_y"},      32'(out_y),      32'd0);
        check({tag, "_out_pixel"},  32'(out_pixel),  32'd0);
    endtask

    // Called at a tick; returns one tick later, when an accepted start has taken effect
    task automatic start_frame(input int w, input int h);
        exp_w       = w;
        exp_h       = h;
        fd_base     = fd_cnt;
        img_width   = CW'(w);
        img_height  = CW'(h);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_frame_done(input int budget, input string tag);
        for (int i = 0; i < budget && fd_cnt == fd_base; i++) tick();
        check({tag, "_frame_done"}, 32'(fd_cnt - fd_base), 32'd1);
        repeat (3) tick();
        check({tag, "_single_done"}, 32'(fd_cnt - fd_base), 32'd1);
        check({tag, "_idle_after"},  32'(busy), 32'd0);
    endtask

    // Window provider: win_valid one cycle after the request is first seen
    initial begin : provider
        bit req_seen;
        req_seen  = 1'b0;
        win_valid = 1'b0;
        win_pix   = 8'h00;
        forever begin
            tick();
            if (win_req && req_seen && !win_valid) begin
                win_valid = 1'b1;
                win_pix   = pix_fn(int'(win_x), int'(win_y));
                req_seen  = 1'b0;
            end else begin
                win_valid = 1'b0;
                req_seen  = win_req;
            end
        end
    end

    // Engine: done nine cycles after start, for done_hold cycles (or sticky), optional spurious pulse in FETCH
    initial begin : engine
        int eng_cnt;
        int hold_cnt;
        bit drop_next;
        bit spur_armed;
        eng_cnt    = 0;
        hold_cnt   = 0;
        drop_next  = 1'b0;
        spur_armed = 1'b0;
        krn_done   = 1'b0;
        krn_pixel  = 8'h00;
        forever begin
            tick();
            if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) krn_done = 1'b0;
            end
            if (drop_next) begin
                krn_done  = 1'b0;
                drop_next = 1'b0;
            end
            if (krn_start) begin
                eng_cnt   = 9;
                drop_next = krn_done;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    krn_done  = 1'b1;
                    krn_pixel = win_pix;
                    hold_cnt  = done_hold;
                end
            end
            if (spur_en && win_req && !spur_armed && !krn_done) begin
                krn_done   = 1'b1;
                krn_pixel  = 8'hEE;
                hold_cnt   = 1;
                spur_armed = 1'b1;
            end
            if (!win_req) spur_armed = 1'b0;
        end
    end

    // Monitor: handshake rules, output order/content, hold under backpressure, per-frame counts
    initial begin : monitor
        int         exp_x;
        int         exp_y;
        bit         stall_prev;
        bit         acc_prev;
        bit         start_prev;
        bit         wv_prev;
        logic [7:0]    held_pix;
        logic [CW-1:0] held_x;
        logic [CW-1:0] held_y;
        exp_x = 0; exp_y = 0;
        stall_prev = 1'b0; acc_prev = 1'b0; start_prev = 1'b0; wv_prev = 1'b0;
        held_pix = '0; held_x = '0; held_y = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_x = 0; exp_y = 0; frame_outs = 0;
                stall_prev = 1'b0; acc_prev = 1'b0; start_prev = 1'b0; wv_prev = 1'b0;
            end else begin
                if (acc_prev) check("accept_to_win_req", 32'(win_req), 32'd1);
                if (stall_prev) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_pixel", 32'(out_pixel), 32'(held_pix));
                    check("hold_x",     32'(out_x),     32'(held_x));
                    check("hold_y",     32'(out_y),     32'(held_y));
                end
                if (krn_start || wv_prev) check("win_valid_to_krn_start", 32'(krn_start), 32'(wv_prev));
                if (krn_start) begin
                    ks_cnt++;
                    check("krn_start_one_cycle", 32'(start_prev), 32'd0);
                end
                if (out_valid) check("quiet_while_emit", 32'({win_req, krn_start}), 32'd0);
                acc_prev   = 1'b0;
                stall_prev = 1'b0;
                if (out_valid && out_ready) begin
                    check("out_x",     32'(out_x),     32'(exp_x));
                    check("out_y",     32'(out_y),     32'(exp_y));
                    check("out_pixel", 32'(out_pixel), 32'(pix_fn(exp_x, exp_y)));
                    frame_outs++;
                    out_total++;
                    if (!(exp_x == exp_w - 3 && exp_y == exp_h - 3)) acc_prev = 1'b1;
                    if (exp_x == exp_w - 3) begin
                        exp_x = 0;
                        exp_y++;
                    end else begin
                        exp_x++;
                    end
                end else if (out_valid) begin
                    stall_prev = 1'b1;
                    stall_cnt++;
                    held_pix = out_pixel;
                    held_x   = out_x;
                    held_y   = out_y;
                end
                if (frame_done) begin
                    fd_cnt++;
                    check("frame_output_count", 32'(frame_outs), 32'(exp_total()));
                    frame_outs = 0;
                    exp_x = 0;
                    exp_y = 0;
                end
                start_prev = krn_start;
                wv_prev    = win_valid && win_req;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int o0;
        int k0;
        int s0;
        rst         = 1'b1;
        frame_start = 1'b0;
        img_width   = '0;
        img_height  = '0;
        out_ready   = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        tick();
        rst = 1'b0;
        tick();

        // 5x5 frame, free-flowing output
        o0 = out_total; k0 = ks_cnt;
        start_frame(5, 5);
        check("t1_win_req_latency", 32'(win_req), 32'd1);
        check("t1_busy",            32'(busy),    32'd1);
        check("t1_first_win_x",     32'(win_x),   32'd0);
        check("t1_first_win_y",     32'(win_y),   32'd0);
        wait_frame_done(2000, "t1");
        check("t1_outputs",   32'(out_total - o0), 32'd9);
        check("t1_krn_start", 32'(ks_cnt - k0),    32'd9);

        // Backpressure: 4 stalled cycles on the second output
        o0 = out_total; k0 = ks_cnt; s0 = stall_cnt;
        start_frame(5, 5);
        for (int i = 0; i < 500 && out_total < o0 + 1; i++) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 500 && !out_valid; i++) tick();
        repeat (4) tick();
        out_ready = 1'b1;
        wait_frame_done(2000, "t2");
        check("t2_stall_cycles", 32'(stall_cnt - s0), 32'd4);
        check("t2_outputs",      32'(out_total - o0), 32'd9);
        check("t2_krn_start",    32'(ks_cnt - k0),    32'd9);

        // Degenerate frames: no window fits
        o0 = out_total;
        start_frame(2, 8);
        check("t3_done_latency", 32'(frame_done), 32'd1);
        check("t3_no_win_req",   32'(win_req),    32'd0);
        tick();
        check("t3_done_pulse",   32'(frame_done), 32'd0);
        wait_frame_done(10, "t3");
        start_frame(8, 2);
        check("t3b_done_latency", 32'(frame_done), 32'd1);
        wait_frame_done(10, "t3b");
        check("t3_outputs", 32'(out_total - o0), 32'd0);

        // Exact-size frame: a single window
        o0 = out_total;
        start_frame(3, 3);
        wait_frame_done(500, "t3c");
        check("t3c_outputs", 32'(out_total - o0), 32'd1);

        // Done held 3 cycles plus spurious done in FETCH
        done_hold = 3; spur_en = 1'b1;
        o0 = out_total; k0 = ks_cnt;
        start_frame(4, 4);
        wait_frame_done(2000, "t4");
        check("t4_outputs",   32'(out_total - o0), 32'd4);
        check("t4_krn_start", 32'(ks_cnt - k0),    32'd4);

        // Done level left high until after the next start
        done_hold = 0; spur_en = 1'b0;
        o0 = out_total; k0 = ks_cnt;
        start_frame(4, 3);
        wait_frame_done(2000, "t4b");
        check("t4b_outputs",   32'(out_total - o0), 32'd2);
        check("t4b_krn_start", 32'(ks_cnt - k0),    32'd2);
        done_hold = 1;

        // frame_start and new dims while busy are ignored
        o0 = out_total;
        start_frame(5, 4);
        for (int i = 0; i < 500 && out_total < o0 + 2; i++) tick();
        img_width   = CW'(9);
        img_height  = CW'(9);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t5_still_busy", 32'(busy), 32'd1);
        wait_frame_done(2000, "t5");
        check("t5_outputs", 32'(out_total - o0), 32'd6);

        // Asynchronous reset while waiting on window (1,1), then restart
        start_frame(5, 5);
        for (int i = 0; i < 1000 && !(krn_start && win_x == CW'(1) && win_y == CW'(1)); i++) tick();
        tick();
        check("t6_in_wait", 32'({busy, win_req, krn_start, out_valid}), 32'b1000);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("t6_async_rst");
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("t6_no_frame_done", 32'(fd_cnt - fd_base), 32'd0);
        o0 = out_total;
        start_frame(4, 4);
        check("t6_restart_req", 32'(win_req), 32'd1);
        check("t6_restart_x",   32'(win_x),   32'd0);
        check("t6_restart_y",   32'(win_y),   32'd0);
        wait_frame_done(2000, "t6");
        check("t6_outputs", 32'(out_total - o0), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
